// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types, slot constants and ID helpers for the two-slot AXI read arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      ADDR   = 2'd2,
      DATA   = 2'd3
   } arb_state_e;

   localparam logic ARB_IFU   = 1'b0;
   localparam logic ARB_LSU   = 1'b1;
   localparam int   ARB_ID_W  = 4;
   localparam int   ARB_LEN_W = 8;

   // The downstream ID carries the owning slot in its MSB so stray responses can be caught.
   function automatic logic [ARB_ID_W-1:0] arb_tag_id(input logic slot,
                                                     input logic [ARB_ID_W-1:0] id);
      return {slot, id[ARB_ID_W-2:0]};
   endfunction

   function automatic logic [ARB_ID_W-1:0] arb_strip_id(input logic [ARB_ID_W-1:0] id);
      return {1'b0, id[ARB_ID_W-2:0]};
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R). master drives AR and RREADY; slave drives ARREADY and R.
interface axi_rd_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import axi_arb_pkg::*;

   logic [ARB_ID_W-1:0]  arid;
   logic [ADDR_W-1:0]    araddr;
   logic [ARB_LEN_W-1:0] arlen;
   logic [2:0]           arsize;
   logic [1:0]           arburst;
   logic                 arvalid;
   logic                 arready;

   logic [ARB_ID_W-1:0]  rid;
   logic [DATA_W-1:0]    rdata;
   logic [1:0]           rresp;
   logic                 rlast;
   logic                 rvalid;
   logic                 rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the slot that did not win last time goes next.
module rr_arb2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt
);

   assign gnt_valid = |req;

   always_comb begin
      gnt = ARB_IFU;
      if (req == 2'b11) begin
         gnt = ~last_grant;
      end else if (req[1]) begin
         gnt = ARB_LSU;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-to-one AXI4 read arbiter (IFU slot 0, LSU slot 1), one burst in flight, AR fully registered.
// ARVALID at N -> ARREADY at N+1 -> M ARVALID at N+2; R path is combinational and follows the granted slot's RREADY.
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   axi_rd_if.slave  s0,
   axi_rd_if.slave  s1,
   axi_rd_if.master m,
   output logic     rlast_err_o,
   output logic     rid_err_o
);

   arb_state_e           state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 last_grant_q, last_grant_d;
   logic [ARB_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [ARB_ID_W-1:0]  arid_q, arid_d;
   logic [ADDR_W-1:0]    araddr_q, araddr_d;
   logic [ARB_LEN_W-1:0] arlen_q, arlen_d;
   logic [2:0]           arsize_q, arsize_d;
   logic [1:0]           arburst_q, arburst_d;

   logic                 pick_vld;
   logic                 pick;

   logic [ARB_ID_W-1:0]  sel_arid;
   logic [ADDR_W-1:0]    sel_araddr;
   logic [ARB_LEN_W-1:0] sel_arlen;
   logic [2:0]           sel_arsize;
   logic [1:0]           sel_arburst;
   logic                 sel_rready;

   logic                 in_data;
   logic                 route0;
   logic                 route1;
   logic                 beat;

   rr_arb2 u_rr_arb2 (
      .req        ({s1.arvalid, s0.arvalid}),
      .last_grant (last_grant_q),
      .gnt_valid  (pick_vld),
      .gnt        (pick)
   );

   always_comb begin
      if (grant_q == ARB_LSU) begin
         sel_arid    = s1.arid;
         sel_araddr  = s1.araddr;
         sel_arlen   = s1.arlen;
         sel_arsize  = s1.arsize;
         sel_arburst = s1.arburst;
         sel_rready  = s1.rready;
      end else begin
         sel_arid    = s0.arid;
         sel_araddr  = s0.araddr;
         sel_arlen   = s0.arlen;
         sel_arsize  = s0.arsize;
         sel_arburst = s0.arburst;
         sel_rready  = s0.rready;
      end
   end

   assign in_data = (state_q == DATA);
   assign route0  = in_data && (grant_q == ARB_IFU);
   assign route1  = in_data && (grant_q == ARB_LSU);
   assign beat    = in_data && m.rvalid && sel_rready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;
      arburst_d    = arburst_q;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = ACCEPT;
            end
         end
         // The granted master still holds ARVALID here, so its fields are safe to capture.
         ACCEPT: begin
            arid_d     = arb_tag_id(grant_q, sel_arid);
            araddr_d   = sel_araddr;
            arlen_d    = sel_arlen;
            arsize_d   = sel_arsize;
            arburst_d  = sel_arburst;
            beat_cnt_d = sel_arlen;
            state_d    = ADDR;
         end
         ADDR: begin
            if (m.arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               if (beat_cnt_q != '0) begin
                  beat_cnt_d = beat_cnt_q - 8'd1;
               end
               if (m.rlast) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= ARB_IFU;
         last_grant_q <= ARB_LSU;
         beat_cnt_q   <= '0;
         arid_q       <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arsize_q     <= '0;
         arburst_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         arid_q       <= arid_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arsize_q     <= arsize_d;
         arburst_q    <= arburst_d;
      end
   end

   assign s0.arready = (state_q == ACCEPT) && (grant_q == ARB_IFU);
   assign s1.arready = (state_q == ACCEPT) && (grant_q == ARB_LSU);

   assign m.arid    = arid_q;
   assign m.araddr  = araddr_q;
   assign m.arlen   = arlen_q;
   assign m.arsize  = arsize_q;
   assign m.arburst = arburst_q;
   assign m.arvalid = (state_q == ADDR);
   assign m.rready  = in_data && sel_rready;

   // Non-owning slot sees an all-zero R channel, so nothing leaks across masters.
   assign s0.rvalid = route0 && m.rvalid;
   assign s0.rdata  = route0 ? m.rdata : {DATA_W{1'b0}};
   assign s0.rid    = route0 ? arb_strip_id(m.rid) : '0;
   assign s0.rresp  = route0 ? m.rresp : 2'b00;
   assign s0.rlast  = route0 && m.rlast;

   assign s1.rvalid = route1 && m.rvalid;
   assign s1.rdata  = route1 ? m.rdata : {DATA_W{1'b0}};
   assign s1.rid    = route1 ? arb_strip_id(m.rid) : '0;
   assign s1.rresp  = route1 ? m.rresp : 2'b00;
   assign s1.rlast  = route1 && m.rlast;

   assign rlast_err_o = beat && (m.rlast ? (beat_cnt_q != '0) : (beat_cnt_q == '0));
   assign rid_err_o   = beat && (m.rid[ARB_ID_W-1] != grant_q);

endmodule
